// File: rtl/sram_access_ctrl_if.sv
// Request/response, word-line and bitline bundle for sram_access_ctrl.
// wr_err exists only when SRAM_ACCESS_CTRL_WRVERIFY_EN is defined.
interface sram_access_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    localparam int ROWS = 2**ADDR_W;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [DATA_W-1:0]      resp_rdata;
    logic [ROWS-1:0]        wl;
    logic                   bl_we;
    logic [DATA_W-1:0]      bl_data;
    logic [ROWS*DATA_W-1:0] row_rdata;
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
    logic                   wr_err;
`endif

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, row_rdata,
        output req_ready, resp_valid, resp_rdata, wl, bl_we, bl_data
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
        , output wr_err
`endif
    );

    // Requester plus array side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, row_rdata,
        input  req_ready, resp_valid, resp_rdata, wl, bl_we, bl_data
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
        , input wr_err
`endif
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// SRAM row access sequencer: SETUP -> word-line PULSE -> HOLD -> (CAPTURE) -> RESP.
// Defining SRAM_ACCESS_CTRL_WRVERIFY_EN adds a write read-back check with sticky wr_err.
module sram_access_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int WL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_access_ctrl_if.slave bus
);
    localparam int         ROWS     = 2**ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(WL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_CAPTURE,
        S_RESP
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
        , S_VPULSE
        , S_VCHECK
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   row_sel;
    logic                accept;
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
    logic                wr_err_q, wr_err_d;
`endif

    assign accept = (state_q == S_IDLE) && bus.req_valid;

    always_comb begin
        row_sel = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (addr_q == ADDR_W'(r)) begin
                row_sel = bus.row_rdata[r*DATA_W +: DATA_W];
            end
        end
    end

    // Control state; async reset takes the word line and bitline enable down at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
            wr_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
            wr_err_q <= wr_err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
        wr_err_d = wr_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                cnt_d   = CNT_LOAD;
            end
            S_PULSE: begin
                // Counter saturates at zero; the exit test is on the current value.
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (!we_q) begin
                    state_d = S_CAPTURE;
                end else begin
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
                    state_d = S_VPULSE;
`else
                    state_d = S_RESP;
`endif
                end
            end
            S_CAPTURE: begin
                state_d = S_RESP;
                rdata_d = row_sel;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
            S_VPULSE: begin
                state_d = S_VCHECK;
            end
            S_VCHECK: begin
                state_d = S_RESP;
                if (row_sel != wdata_q) begin
                    wr_err_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.wl         = '0;
        bus.bl_we      = 1'b0;
        bus.bl_data    = '0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
            end
            S_SETUP, S_HOLD: begin
                bus.bl_we   = we_q;
                bus.bl_data = we_q ? wdata_q : '0;
            end
            S_PULSE: begin
                bus.wl[addr_q] = 1'b1;
                bus.bl_we      = we_q;
                bus.bl_data    = we_q ? wdata_q : '0;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
            end
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
            // Read-back pulse: row is driven but bitlines are released.
            S_VPULSE: begin
                bus.wl[addr_q] = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign bus.resp_rdata = rdata_q;
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
    assign bus.wr_err = wr_err_q;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: per-cycle vector table plus hand sequences for
// long pulses, async reset mid-pulse and (with SRAM_ACCESS_CTRL_WRVERIFY_EN) write-verify.
module tb_sram_access_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic stuck5;
    logic [31:0] mem [16];
    int checks = 0;
    int errors = 0;

`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
    localparam int WR_LAT = 5;
`else
    localparam int WR_LAT = 3;
`endif

    always #5 clk = ~clk;

    sram_access_ctrl_if #(.ADDR_W(4), .DATA_W(32)) bus ();
    sram_access_ctrl_if #(.ADDR_W(4), .DATA_W(32)) bus4 ();

    sram_access_ctrl #(.ADDR_W(4), .DATA_W(32), .WL_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    sram_access_ctrl #(.ADDR_W(4), .DATA_W(32), .WL_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    // Row array model: rows written while selected with bl_we, row 5 can be forced to read 0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 16; r++) mem[r] <= 32'hA0A0_0000 | 32'(r);
        end else if (bus.bl_we) begin
            for (int r = 0; r < 16; r++) if (bus.wl[r]) mem[r] <= bus.bl_data;
        end
    end

    always_comb begin
        bus.row_rdata  = '0;
        bus4.row_rdata = '0;
        for (int r = 0; r < 16; r++) begin
            bus.row_rdata[r*32 +: 32]  = (stuck5 && r == 5) ? 32'h0 : mem[r];
            bus4.row_rdata[r*32 +: 32] = mem[r];
        end
    end

    typedef struct {
        logic        rv;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic        rr;
        logic        e_rdy;
        logic        e_rvld;
        logic [15:0] e_wl;
        logic        e_blwe;
        logic [31:0] e_bld;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic vec(input logic rv, input logic we, input logic [3:0] a, input logic [31:0] wd,
                       input logic rr, input logic e_rdy, input logic e_rvld, input logic [15:0] e_wl,
                       input logic e_blwe, input logic [31:0] e_bld, input logic [31:0] e_rd);
        vec_t v;
        v.rv = rv; v.we = we; v.addr = a; v.wd = wd; v.rr = rr;
        v.e_rdy = e_rdy; v.e_rvld = e_rvld; v.e_wl = e_wl;
        v.e_blwe = e_blwe; v.e_bld = e_bld; v.e_rd = e_rd;
        tbl.push_back(v);
    endtask

    // One vector per cycle: IDLE (handshake) .. RESP (accepted).
    task automatic add_write(input logic [3:0] a, input logic [31:0] d, input logic [31:0] prev);
        logic [15:0] w;
        w = 16'h1 << a;
        vec(1'b1, 1'b1, a, d, 1'b1,   1'b1, 1'b0, '0, 1'b0, '0, prev);
        vec(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, d, prev);
        vec(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, w,  1'b1, d, prev);
        vec(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, d, prev);
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
        vec(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, w,  1'b0, '0, prev);
        vec(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, prev);
`endif
        vec(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, '0, 1'b0, '0, prev);
    endtask

    // Requests presented while busy (other address, write) must have no effect.
    task automatic add_read(input logic [3:0] a, input logic [31:0] prev, input logic [31:0] d,
                            input int stall);
        logic [15:0] w;
        logic [3:0]  na;
        w  = 16'h1 << a;
        na = a ^ 4'h1;
        vec(1'b1, 1'b0, a, 32'h5555_AAAA, 1'b1,  1'b1, 1'b0, '0, 1'b0, '0, prev);
        vec(1'b1, 1'b1, na, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, prev);
        vec(1'b1, 1'b1, na, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, w,  1'b0, '0, prev);
        vec(1'b1, 1'b1, na, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, prev);
        vec(1'b1, 1'b1, na, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, prev);
        for (int s = 0; s < stall; s++)
            vec(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0, d);
        vec(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, '0, 1'b0, '0, d);
    endtask

    task automatic do_txn(input logic we, input logic [3:0] a, input logic [31:0] d, output int lat);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            #1;
            if (bus.resp_valid) lat = k;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wl_cnt, bad_wl, bad_cyc;

        add_write(4'd3, 32'hDEAD_BEEF, 32'h0);
        add_read(4'd3, 32'h0, 32'hDEAD_BEEF, 0);
        add_write(4'd9, 32'h0000_00A5, 32'hDEAD_BEEF);
        add_read(4'd9, 32'hDEAD_BEEF, 32'h0000_00A5, 5);
        vec(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 32'h0000_00A5);

        rst = 1'b1;
        stuck5 = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b1;
        bus4.req_valid = 1'b0; bus4.req_we = 1'b0; bus4.req_addr = '0; bus4.req_wdata = '0;
        bus4.resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst resp_rdata", 64'(bus.resp_rdata), 64'd0);
        check("rst wl", 64'(bus.wl), 64'd0);
        check("rst bl_we", 64'(bus.bl_we), 64'd0);
        check("rst bl_data", 64'(bus.bl_data), 64'd0);
`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
        check("rst wr_err", 64'(bus.wr_err), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst req_ready", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            bus.req_valid = tbl[i].rv; bus.req_we = tbl[i].we; bus.req_addr = tbl[i].addr;
            bus.req_wdata = tbl[i].wd; bus.resp_ready = tbl[i].rr;
            #1;
            check($sformatf("v%0d req_ready", i), 64'(bus.req_ready), 64'(tbl[i].e_rdy));
            check($sformatf("v%0d resp_valid", i), 64'(bus.resp_valid), 64'(tbl[i].e_rvld));
            check($sformatf("v%0d wl", i), 64'(bus.wl), 64'(tbl[i].e_wl));
            check($sformatf("v%0d bl_we", i), 64'(bus.bl_we), 64'(tbl[i].e_blwe));
            check($sformatf("v%0d bl_data", i), 64'(bus.bl_data), 64'(tbl[i].e_bld));
            check($sformatf("v%0d resp_rdata", i), 64'(bus.resp_rdata), 64'(tbl[i].e_rd));
        end

        // Four-cycle word-line pulse on the second instance.
        @(negedge clk);
        bus4.req_valid = 1'b1; bus4.req_we = 1'b0; bus4.req_addr = 4'd15;
        @(negedge clk);
        bus4.req_valid = 1'b0;
        lat = -1; wl_cnt = 0; bad_wl = 0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            #1;
            if (bus4.wl == 16'h8000) wl_cnt++;
            else if (bus4.wl != 16'h0) bad_wl++;
            if (bus4.resp_valid) lat = k;
            @(negedge clk);
        end
        check("wl4 latency", 64'(lat), 64'd7);
        check("wl4 pulse cycles", 64'(wl_cnt), 64'd4);
        check("wl4 stray wl", 64'(bad_wl), 64'd0);
        check("wl4 resp_rdata", 64'(bus4.resp_rdata), 64'hA0A0_000F);

        // Plain write/read latency and data.
        do_txn(1'b1, 4'd7, 32'h0BAD_F00D, lat);
        check("write latency", 64'(lat), 64'(WR_LAT));
        do_txn(1'b0, 4'd7, 32'h0, lat);
        check("read latency", 64'(lat), 64'd4);
        check("read 7 rdata", 64'(bus.resp_rdata), 64'h0BAD_F00D);

        // Reset in the middle of a write pulse.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd6; bus.req_wdata = 32'h77;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("pre-rst pulse wl", 64'(bus.wl), 64'h0040);
        check("pre-rst pulse bl_we", 64'(bus.bl_we), 64'd1);
        rst = 1'b1;
        #1;
        check("async rst wl", 64'(bus.wl), 64'd0);
        check("async rst bl_we", 64'(bus.bl_we), 64'd0);
        check("async rst resp_rdata", 64'(bus.resp_rdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad_cyc = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (bus.resp_valid || !bus.req_ready) bad_cyc++;
            @(negedge clk);
        end
        check("post-rst idle cycles", 64'(bad_cyc), 64'd0);

`ifdef SRAM_ACCESS_CTRL_WRVERIFY_EN
        check("wr_err before bad write", 64'(bus.wr_err), 64'd0);
        stuck5 = 1'b1;
        do_txn(1'b1, 4'd5, 32'h1, lat);
        check("verify write latency", 64'(lat), 64'd5);
        check("wr_err after bad write", 64'(bus.wr_err), 64'd1);
        stuck5 = 1'b0;
        do_txn(1'b1, 4'd3, 32'h12, lat);
        check("wr_err after good write", 64'(bus.wr_err), 64'd1);
        do_txn(1'b0, 4'd3, 32'h0, lat);
        check("readback row 3", 64'(bus.resp_rdata), 64'h12);
        check("wr_err still set", 64'(bus.wr_err), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, row-address width; ROWS = 2**ADDR_W.
REQ-002 The block SHALL have parameter DATA_W, default 32, word width.
REQ-003 The block SHALL have parameter WL_CYCLES, default 1, word-line pulse length in clocks; legal range 1..15.
REQ-004 The block SHALL have these ports, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  row address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response available.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  DATA_W  read data.
- wl  out  ROWS  one-hot word-line strobes, bit n drives row n.
- bl_we  out  1  bitline write enable.
- bl_data  out  DATA_W  bitline write data to all rows.
- row_rdata  in  ROWS*DATA_W  concatenated row outputs, row n at bits [n*DATA_W +: DATA_W].
- wr_err  out  1  sticky write-verify mismatch; present only with the macro.
REQ-005 Reset SHALL be asynchronous and active-high, on port rst; all state SHALL be clocked by clk.

Function
REQ-006 The FSM SHALL have the states IDLE, SETUP, PULSE, HOLD, CAPTURE, RESP; the states VPULSE and VCHECK SHALL exist only with the macro.
REQ-007 req_ready SHALL be 1 only in IDLE; the handshake completes on a clock edge where req_valid and req_ready are both 1.
REQ-008 On handshake, the block SHALL latch req_we, req_addr and req_wdata, then go IDLE -> SETUP.
REQ-009 SETUP SHALL last 1 cycle, with wl all-zero, bl_we = latched we, and bl_data = latched wdata for writes or 0 for reads.
REQ-010 PULSE SHALL last exactly WL_CYCLES cycles, with wl[addr] = 1 and all other wl bits 0, while bl_we and bl_data hold their SETUP values.
REQ-011 HOLD SHALL last 1 cycle, with wl all-zero and bl_we and bl_data still held; then a read goes to CAPTURE and a write goes to RESP.
REQ-012 CAPTURE SHALL last 1 cycle, register row_rdata slice [addr] into resp_rdata, and go to RESP.
REQ-013 In RESP, resp_valid SHALL be 1 until resp_ready = 1 at a clock edge; the block then returns to IDLE in the following cycle.
REQ-014 Back-to-back requests SHALL be spaced by at least one IDLE cycle.
REQ-015 Latency with resp_ready held at 1, counted from the handshake edge to the first resp_valid = 1 cycle, SHALL be:
- read: 3 + WL_CYCLES cycles;
- write: 2 + WL_CYCLES cycles.
REQ-016 resp_rdata SHALL keep its value through write responses and change only in CAPTURE.
REQ-017 wl SHALL never have more than one bit set, and SHALL be all-zero in every state except PULSE and VPULSE.
REQ-018 bl_we SHALL be 0 in IDLE, CAPTURE, RESP, VPULSE and VCHECK.
REQ-019 req_valid asserted outside IDLE SHALL be ignored, with no latch and no effect.
REQ-020 The pulse counter SHALL be 4 bits wide, load WL_CYCLES-1 on entering PULSE, and leave PULSE when it reaches 0; it SHALL not wrap.

Reset
REQ-021 While rst = 1, the FSM SHALL be in IDLE and req_ready SHALL be 1 once rst is released.
REQ-022 While rst = 1, the outputs SHALL be: resp_valid = 0, resp_rdata = 0, wl = 0, bl_we = 0, bl_data = 0, wr_err = 0.
REQ-023 rst asserted mid-transaction SHALL drop wl and bl_we in the same cycle, asynchronously, and the pending request SHALL be discarded with no response.

Configuration
REQ-024 Macro SRAM_ACCESS_CTRL_WRVERIFY_EN defined: a write SHALL take the path HOLD -> VPULSE -> VCHECK -> RESP.
- VPULSE: 1 cycle, wl[addr] = 1, bl_we = 0.
- VCHECK: 1 cycle, compares row_rdata[addr] with the latched wdata; any mismatch sets wr_err, which is cleared only by rst.
- Write latency becomes 4 + WL_CYCLES cycles.
REQ-025 Macro absent: wr_err, VPULSE and VCHECK SHALL not exist, and writes SHALL follow REQ-011.

Verification
REQ-026 The bench SHALL cover these scenarios (defaults, resp_ready = 1):
- Write addr 3, data 0xDEADBEEF -> wl = 0x0008 for 1 cycle; bl_we = 1 and bl_data = 0xDEADBEEF across SETUP..HOLD; resp_valid in cycle 3.
- Read addr 3 with the row model returning 0xDEADBEEF -> resp_rdata = 0xDEADBEEF with resp_valid in cycle 4; bl_we = 0 throughout.
- WL_CYCLES = 4, read addr 15 -> wl = 0x8000 for exactly 4 cycles; resp_valid in cycle 7.
- Hold resp_ready = 0 for 5 cycles -> resp_valid held with stable resp_rdata; req_ready = 0 until the cycle after resp_ready = 1.
- Assert rst during PULSE -> wl = 0 immediately; no resp_valid; req_ready = 1 after release.
- With the macro, row model returns 0x0 for a write of 0x1 -> wr_err = 1 and stays 1 across later good writes.
